// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding / interlock unit: default widths, stage indices,
// result latency classes and a saturating counter helper.
package fwd_pkg;

    localparam int REG_AW_DEF  = 5;
    localparam int SEL_REGFILE = 0;

    localparam int STG_MEM = 0;
    localparam int STG_WB  = 1;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Priority scan for one EX operand: picks the youngest downstream stage writing the
// operand's register and flags when that stage's value is not yet valid.
module fwd_src_select
    import fwd_pkg::*;
#(
    parameter int FWD_STAGES = 2,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic [REG_AW-1:0]            i_rs,
    input  logic [FWD_STAGES*REG_AW-1:0] i_stg_rd,
    input  logic [FWD_STAGES-1:0]        i_stg_regwrite,
    input  logic [FWD_STAGES-1:0]        i_stg_data_ok,
    output logic [SEL_W-1:0]             o_sel,
    output logic                         o_data_bad
);

    logic [FWD_STAGES-1:0] w_match;

    genvar gi;
    generate
        for (gi = 0; gi < FWD_STAGES; gi++) begin : g_match
            assign w_match[gi] = i_stg_regwrite[gi]
                               && (i_stg_rd[gi*REG_AW +: REG_AW] != '0)
                               && (i_stg_rd[gi*REG_AW +: REG_AW] == i_rs);
        end
    endgenerate

    // Walk oldest to youngest so the youngest matching stage is the last to assign.
    always_comb begin
        o_sel      = SEL_W'(SEL_REGFILE);
        o_data_bad = 1'b0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (w_match[k]) begin
                o_sel      = SEL_W'(k + 1);
                o_data_bad = ~i_stg_data_ok[k];
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX operand bypass selection plus a per-register latency scoreboard that interlocks ID
// on multi-cycle results, with a stall counter and a sticky forwarding-error flag.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int REG_AW     = REG_AW_DEF,
    parameter int MAX_LAT    = 3,
    localparam int SEL_W     = $clog2(FWD_STAGES + 1),
    localparam int LAT_W     = $clog2(MAX_LAT + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic                         id_kill,
    input  logic [NUM_SRC*REG_AW-1:0]    id_rs,
    input  logic [NUM_SRC-1:0]           id_rs_en,
    input  logic [REG_AW-1:0]            id_rd,
    input  logic                         id_regwrite,
    input  logic [LAT_W-1:0]             id_lat,
    input  logic [NUM_SRC*REG_AW-1:0]    ex_rs,
    input  logic [FWD_STAGES*REG_AW-1:0] stg_rd,
    input  logic [FWD_STAGES-1:0]        stg_regwrite,
    input  logic [FWD_STAGES-1:0]        stg_data_ok,
    output logic [NUM_SRC*SEL_W-1:0]     fwd_sel,
    output logic                         stall,
    output logic [31:0]                  stall_cnt,
    output logic                         hazard_err
);

    localparam int NUM_REGS = 2 ** REG_AW;

    logic [LAT_W-1:0]   w_cnt [NUM_REGS];
    logic [LAT_W-1:0]   w_lat_clamp;
    logic [NUM_SRC-1:0] w_src_hz;
    logic [NUM_SRC-1:0] w_src_bad;
    logic               w_issue;

    logic [31:0]        r_stall_cnt;
    logic               r_hazard_err;

    genvar gi;

    // Forwarding: one independent priority scan per EX operand.
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_src_select #(
                .FWD_STAGES (FWD_STAGES),
                .REG_AW     (REG_AW),
                .SEL_W      (SEL_W)
            ) u_sel (
                .i_rs           (ex_rs[gi*REG_AW +: REG_AW]),
                .i_stg_rd       (stg_rd),
                .i_stg_regwrite (stg_regwrite),
                .i_stg_data_ok  (stg_data_ok),
                .o_sel          (fwd_sel[gi*SEL_W +: SEL_W]),
                .o_data_bad     (w_src_bad[gi])
            );

            assign w_src_hz[gi] = id_rs_en[gi]
                                && (id_rs[gi*REG_AW +: REG_AW] != '0)
                                && (w_cnt[id_rs[gi*REG_AW +: REG_AW]] != '0);
        end
    endgenerate

    // Clamp only matters when the latency field can encode values above MAX_LAT.
    generate
        if (((1 << LAT_W) - 1) > MAX_LAT) begin : g_clamp
            assign w_lat_clamp = (id_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : id_lat;
        end else begin : g_noclamp
            assign w_lat_clamp = id_lat;
        end
    endgenerate

    assign stall   = ~rst & id_valid & ~id_kill & (|w_src_hz);
    assign w_issue = id_valid & ~id_kill & ~stall & id_regwrite & (id_rd != '0);

    // Scoreboard: x0 never holds a pending result; a new issue overrides the decrement.
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_sb
            if (gi == 0) begin : g_zero
                assign w_cnt[gi] = '0;
            end else begin : g_reg
                logic [LAT_W-1:0] r_cnt;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_cnt <= '0;
                    end else if (w_issue && (id_rd == REG_AW'(gi))) begin
                        r_cnt <= w_lat_clamp;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                assign w_cnt[gi] = r_cnt;
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt  <= '0;
            r_hazard_err <= 1'b0;
        end else begin
            if (stall) begin
                r_stall_cnt <= sat_inc32(r_stall_cnt);
            end
            if (|w_src_bad) begin
                r_hazard_err <= 1'b1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign hazard_err = r_hazard_err;

endmodule
